// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: raster-scan sequencer for the 3x3 Sobel datapath.
// Counts the column and row of each accepted pixel, drives the line-buffer
// write address and rotate strobes, and emits a valid/ready window stream
// tagged with the window-centre coordinates.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 begin a frame (only acted on when idle)
//   valid_i / ready_o       upstream pixel handshake
//   valid_o / ready_i       downstream window handshake
//   ctr_col_o / ctr_row_o   centre coordinates of the presented window
//   lb_wr_en_o/lb_wr_addr_o line-buffer write strobe and column address
//   lb_rot_o                rotate line buffers after the last column
//   frame_done_o            one-cycle end-of-frame pulse
//   busy_o                  frame in progress
module sobel_window_ctrl #(
  parameter int WIDTH_P  = 640,
  parameter int HEIGHT_P = 480,
  parameter int COL_W_P  = $clog2(WIDTH_P),
  parameter int ROW_W_P  = $clog2(HEIGHT_P)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [COL_W_P-1:0] ctr_col_o,
  output logic [ROW_W_P-1:0] ctr_row_o,
  output logic               lb_wr_en_o,
  output logic [COL_W_P-1:0] lb_wr_addr_o,
  output logic               lb_rot_o,
  output logic               frame_done_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [COL_W_P-1:0] LAST_COL = COL_W_P'(WIDTH_P - 1);
  localparam logic [ROW_W_P-1:0] LAST_ROW = ROW_W_P'(HEIGHT_P - 1);
  localparam logic [COL_W_P-1:0] COL_ONE  = COL_W_P'(1);
  localparam logic [ROW_W_P-1:0] ROW_ONE  = ROW_W_P'(1);
  localparam logic [COL_W_P-1:0] COL_TWO  = COL_W_P'(2);
  localparam logic [ROW_W_P-1:0] ROW_TWO  = ROW_W_P'(2);

  state_t             r_state;
  logic [COL_W_P-1:0] r_col;
  logic [ROW_W_P-1:0] r_row;
  logic               r_valid;
  logic [COL_W_P-1:0] r_ctr_col;
  logic [ROW_W_P-1:0] r_ctr_row;

  logic w_active;
  logic w_free;
  logic w_acc;
  logic w_xfer;
  logic w_last_col;
  logic w_last_row;
  logic w_win;

  always_comb begin
    w_active   = (r_state == S_FILL) | (r_state == S_RUN);
    // Output slot is free if empty or being drained this cycle.
    w_free     = !r_valid | ready_i;
    w_acc      = valid_i & w_active & w_free;
    w_xfer     = r_valid & ready_i;
    w_last_col = (r_col == LAST_COL);
    w_last_row = (r_row == LAST_ROW);
    // A full 3x3 neighbourhood exists once two rows and two columns are behind.
    w_win      = (r_row >= ROW_TWO) & (r_col >= COL_TWO);
  end

  assign ready_o      = w_active & w_free;
  assign valid_o      = r_valid;
  assign ctr_col_o    = r_ctr_col;
  assign ctr_row_o    = r_ctr_row;
  assign lb_wr_en_o   = w_acc;
  assign lb_wr_addr_o = r_col;
  assign lb_rot_o     = w_acc & w_last_col;
  assign frame_done_o = (r_state == S_DONE) & w_free;
  assign busy_o       = (r_state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
      r_ctr_col <= '0;
      r_ctr_row <= '0;
    end else begin
      if (w_acc) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + ROW_ONE;
        end else begin
          r_col <= r_col + COL_ONE;
        end
      end

      // A new window overrides the clear from a same-cycle transfer.
      if (w_acc & w_win) begin
        r_valid   <= 1'b1;
        r_ctr_col <= r_col - COL_ONE;
        r_ctr_row <= r_row - ROW_ONE;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_FILL;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        S_FILL: begin
          if (w_acc & w_last_col & (r_row == ROW_ONE))
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_acc & w_last_col & w_last_row)
            r_state <= S_DONE;
        end
        S_DONE: begin
          if (w_free)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: directed bench for sobel_window_ctrl on a 4x4 frame.
// Expected window centres are queued at pixel accept and popped on transfer.
module tb_sobel_window_ctrl;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk;
  logic       rst_i;
  logic       start_i;
  logic       valid_i;
  logic       ready_o;
  logic       valid_o;
  logic       ready_i;
  logic [1:0] ctr_col_o;
  logic [1:0] ctr_row_o;
  logic       lb_wr_en_o;
  logic [1:0] lb_wr_addr_o;
  logic       lb_rot_o;
  logic       frame_done_o;
  logic       busy_o;

  int checks;
  int errors;
  int popped;
  int m_col;
  int m_row;
  logic [7:0] q[$];
  logic [7:0] m_exp;

  sobel_window_ctrl #(
    .WIDTH_P (W),
    .HEIGHT_P(H)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ctr_col_o   (ctr_col_o),
    .ctr_row_o   (ctr_row_o),
    .lb_wr_en_o  (lb_wr_en_o),
    .lb_wr_addr_o(lb_wr_addr_o),
    .lb_rot_o    (lb_rot_o),
    .frame_done_o(frame_done_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window scoreboard: every transfer must match the oldest queued centre.
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      chk("spurious_window", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        m_exp = q.pop_front();
        chk("window_ctr", 32'({2'b00, ctr_row_o, 2'b00, ctr_col_o}), 32'(m_exp));
        popped++;
      end
    end
  end

  // Offers one pixel and waits (bounded) for it to be accepted.
  task automatic send_pixel(output int waits);
    bit got;
    got   = 0;
    waits = 0;
    valid_i = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1;
        chk("wr_en", 32'(lb_wr_en_o), 1);
        chk("wr_addr", 32'(lb_wr_addr_o), 32'(m_col));
        chk("rot", 32'(lb_rot_o), 32'(m_col == W - 1));
        if (m_row >= 2 && m_col >= 2)
          q.push_back(8'(((m_row - 1) << 4) | (m_col - 1)));
        if (m_col == W - 1) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("accept_timeout", 32'(ready_o), 1);
  endtask

  task automatic send_n(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      send_pixel(w);
      chk("no_bubble", 32'(w), 0);
    end
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(busy_o), 1);
    chk("start_addr", 32'(lb_wr_addr_o), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame(input int p0, output int lat);
    bit found;
    found = 0;
    lat = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (frame_done_o) found = 1;
      else lat++;
      @(posedge clk);
      #1;
    end
    chk("frame_done_seen", 32'(found), 1);
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done", 32'(frame_done_o), 0);
    chk("idle_valid", 32'(valid_o), 0);
    chk("queue_empty", 32'(q.size()), 0);
    chk("windows_per_frame", 32'(popped - p0), 4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    int lat;
    int w;
    checks  = 0;
    errors  = 0;
    popped  = 0;
    m_col   = 0;
    m_row   = 0;
    rst_i   = 1'b1;
    start_i = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b1;

    // 1. reset overrides start/valid
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ctr_col", 32'(ctr_col_o), 0);
    chk("rst_ctr_row", 32'(ctr_row_o), 0);
    chk("rst_done", 32'(frame_done_o), 0);
    chk("rst_wr_en", 32'(lb_wr_en_o), 0);
    @(posedge clk);
    #1;
    rst_i   = 1'b0;
    start_i = 1'b0;
    valid_i = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_ready", 32'(ready_o), 0);
    @(posedge clk);
    #1;

    // 2. back-to-back frame
    p0 = popped;
    start_frame();
    send_n(16);
    finish_frame(p0, lat);
    chk("done_latency", 32'(lat), 0);

    // 3. downstream stall on first window
    p0 = popped;
    start_frame();
    send_n(11);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(ready_o), 0);
      chk("stall_wr_en", 32'(lb_wr_en_o), 0);
      chk("stall_valid", 32'(valid_o), 1);
      chk("stall_ctr_row", 32'(ctr_row_o), 1);
      chk("stall_ctr_col", 32'(ctr_col_o), 1);
      chk("stall_addr", 32'(lb_wr_addr_o), 32'(m_col));
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    send_pixel(w);
    chk("resume_wait", 32'(w), 0);
    send_n(4);
    finish_frame(p0, lat);

    // 4. valid_i toggling
    p0 = popped;
    start_frame();
    for (int i = 0; i < 16; i++) begin
      send_pixel(w);
      if (i != 15) begin
        valid_i = 1'b0;
        @(negedge clk);
        chk("gap_wr_en", 32'(lb_wr_en_o), 0);
        chk("gap_addr", 32'(lb_wr_addr_o), 32'(m_col));
        @(posedge clk);
        #1;
      end
    end
    finish_frame(p0, lat);

    // 5. reset mid-frame
    start_frame();
    send_n(7);
    valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_col = 0;
    m_row = 0;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_valid", 32'(valid_o), 0);
    chk("abort_ready", 32'(ready_o), 0);
    chk("abort_queue", 32'(q.size()), 0);
    @(posedge clk);
    #1;
    p0 = popped;
    start_frame();
    send_n(16);
    finish_frame(p0, lat);

    // 6. start_i ignored while busy; DONE waits for drain
    p0 = popped;
    start_frame();
    send_n(2);
    valid_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    @(negedge clk);
    chk("fill_start_busy", 32'(busy_o), 1);
    chk("fill_start_addr", 32'(lb_wr_addr_o), 32'(m_col));
    chk("fill_start_valid", 32'(valid_o), 0);
    @(posedge clk);
    #1;
    send_n(8);
    valid_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    @(negedge clk);
    chk("run_start_busy", 32'(busy_o), 1);
    chk("run_start_addr", 32'(lb_wr_addr_o), 32'(m_col));
    chk("run_start_ready", 32'(ready_o), 1);
    @(posedge clk);
    #1;
    send_n(6);
    valid_i = 1'b0;
    ready_i = 1'b0;
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_hold_pulse", 32'(frame_done_o), 0);
      chk("done_hold_busy", 32'(busy_o), 1);
      chk("done_hold_valid", 32'(valid_o), 1);
      chk("done_hold_row", 32'(ctr_row_o), 2);
      chk("done_hold_col", 32'(ctr_col_o), 2);
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    finish_frame(p0, lat);
    chk("done_release_latency", 32'(lat), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
Raster-scan sequencer for the 3x3 Sobel datapath. Tracks column/row of an incoming pixel stream using wrap-around column/row counters. Drives line-buffer write address and rotate strobes, and emits a valid/ready window stream tagged with the window-centre coordinates. Sits between the pixel source and the line buffers/Sobel kernel, one instance per frame pipeline.

Parameters:
WIDTH_P, 640, pixels per line; legal values are >= 3.
HEIGHT_P, 480, lines per frame; legal values are >= 3.
COL_W_P, $clog2(WIDTH_P), column counter/address width.
ROW_W_P, $clog2(HEIGHT_P), row counter width.

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  begin a frame; honoured only in IDLE
valid_i  input  1  upstream pixel valid
ready_o  output  1  upstream ready; accept = valid_i & ready_o
valid_o  output  1  window valid to kernel
ready_i  input  1  kernel ready; transfer = valid_o & ready_i
ctr_col_o  output  COL_W_P  centre column of presented window
ctr_row_o  output  ROW_W_P  centre row of presented window
lb_wr_en_o  output  1  line-buffer write strobe, equal to accept (combinational)
lb_wr_addr_o  output  COL_W_P  line-buffer write address = current column counter
lb_rot_o  output  1  rotate line buffers; accept of last column (col==WIDTH_P-1), combinational
frame_done_o  output  1  one-cycle end-of-frame pulse
busy_o  output  1  state != IDLE

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE, col=0, row=0, valid_o=0, ctr_col_o=0, ctr_row_o=0. Combinational outputs are then 0 (ready_o=0 in IDLE). Reset overrides every other input and aborts a frame mid-operation; no partial flush.
- States: IDLE, FILL, RUN, DONE.
  - IDLE: ready_o=0. On start_i go to FILL.
  - FILL: rows 0..1 being loaded. Go to RUN on accept at col=WIDTH_P-1, row=1.
  - RUN: go to DONE on accept at col=WIDTH_P-1, row=HEIGHT_P-1.
  - DONE: ready_o=0. When !valid_o | ready_i: pulse frame_done_o (combinational, same cycle), go to IDLE.
- start_i is ignored in FILL/RUN/DONE.
- ready_o = (state in FILL/RUN) & (!valid_o | ready_i). This is a single-stage pipeline, so full throughput is possible with no bubble.
- Counters advance only on accept.
  - col increments; at WIDTH_P-1 it wraps to 0 and row increments.
  - row at HEIGHT_P-1 with col wrap goes to 0.
  - No gap cycles or valid_i low cycles move the counters.
- Window generation: on accept with row>=2 and col>=2, next cycle valid_o=1, ctr_col_o=col-1, ctr_row_o=row-1. Latency is 1 cycle.
- Accept with row<2 or col<2 (border) loads nothing. valid_o clears on transfer unless reloaded the same cycle.
- While valid_o & !ready_i: valid_o, ctr_* are held stable, ready_o=0, and counters are frozen.
- Windows per frame = (WIDTH_P-2)*(HEIGHT_P-2). Border outputs are not generated.
- Arithmetic: centre = counter-1 in counter width. Underflow is impossible by the window condition.
- Simultaneous transfer and accept in the same cycle: the new window replaces the old one, with no loss.

Test Plan:
All scenarios use WIDTH_P=4, HEIGHT_P=4.
1. Assert rst_i 2 cycles -> valid_o=0, ready_o=0, busy_o=0, ctr_col_o=0, ctr_row_o=0, frame_done_o=0.
2. start_i, then 16 pixels back-to-back with ready_i=1 -> accepts on 16 consecutive cycles. valid_o appears the cycle after accepts #11, #12, #15, #16, with centres (r,c)=(1,1),(1,2),(2,1),(2,2). lb_rot_o pulses on accepts #4, #8, #12, #16. frame_done_o pulses once the cycle after #16, then busy_o=0.
3. Same frame with ready_i=0 for 3 cycles while valid_o holds centre (1,1) -> ready_o=0, centre held, lb_wr_en_o=0. On ready_i=1, transfer occurs and the stream resumes with no window lost or duplicated.
4. valid_i toggling 1/0 every cycle -> lb_wr_addr_o sequence 0,1,2,3,0,... advances only on accepts. The same 4 windows are produced.
5. rst_i asserted after 7 accepts -> next cycle IDLE, valid_o=0. A new start_i frame starts at col=0/row=0 and yields exactly 4 windows.
6. start_i pulsed in FILL, RUN and DONE -> no state, counter or output change. In DONE with valid_o=1 and ready_i=0, frame_done_o is held off until ready_i=1.
